// File: rtl/bios_burst_sink.sv
// Consumer end of the BIOS download handshake: bursts a half-buffer into a line buffer,
// then commits it word by word to memory. Optional checksum: BIOS_BURST_SINK_CHECKSUM_EN.
module bios_burst_sink #(
    parameter int unsigned       BURST     = 32,
    parameter int unsigned       ADDR_W    = 18,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 18'h3F000
) (
    input  logic              clk_sdr,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              bios_wr,
    input  logic [15:0]       bios_din,
    output logic              bios_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_dout,
    input  logic              mem_ack,
    output logic              busy,
    output logic [15:0]       words_done
`ifdef BIOS_BURST_SINK_CHECKSUM_EN
    ,
    output logic [15:0]       checksum,
    output logic              sum_valid
`endif
);

    localparam int unsigned      CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BURST - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StDrain, StWaitClr, StWrite} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_rptr;
    logic [1:0]        r_vld;
    logic [15:0]       r_din;
    logic              r_drain;
    logic              r_ld_pend;
    logic              r_bios_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_dout;
    logic [15:0]       r_words_done;
    logic [15:0]       r_buf [BURST];

    logic              w_ack;
    logic              w_last_ack;
    logic              w_ld_ok;
    logic              w_clr;
    logic [CNT_W-1:0]  w_rptr_nxt;
    logic [CNT_W-1:0]  w_rd_idx;
    logic [15:0]       w_rd_data;

    assign w_ack      = (r_state == StWrite) && r_mem_we && mem_ack;
    assign w_last_ack = w_ack && (r_rptr == LAST);
    assign w_ld_ok    = (r_state == StIdle) || (r_state == StWaitClr);
    // A latched load_start lands on the same edge that re-enters IDLE.
    assign w_clr      = (load_start && w_ld_ok) || (w_last_ack && (r_ld_pend || load_start));
    assign w_rptr_nxt = r_rptr + 1'b1;
    assign w_rd_idx   = (r_state == StWrite) ? w_rptr_nxt : '0;
    assign w_rd_data  = r_buf[w_rd_idx];

    always_ff @(posedge clk_sdr) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_vld      <= 2'b00;
            r_drain    <= 1'b0;
            r_ld_pend  <= 1'b0;
            r_bios_req <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_dout <= 16'h0000;
        end else begin
            // Producer answers a request one cycle late; data is sampled one edge after that.
            r_vld <= {r_vld[0], r_bios_req};
            if (r_vld[1]) r_wptr <= r_wptr + 1'b1;
            if (w_clr) r_ld_pend <= 1'b0;
            else if (load_start) r_ld_pend <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (bios_wr) begin
                        r_state    <= StFetch;
                        r_bios_req <= 1'b1;
                        r_cnt      <= '0;
                        r_wptr     <= '0;
                    end
                end
                StFetch: begin
                    if (r_cnt == LAST) begin
                        r_bios_req <= 1'b0;
                        r_drain    <= 1'b0;
                        r_state    <= StDrain;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDrain: begin
                    if (r_drain) r_state <= StWaitClr;
                    else r_drain <= 1'b1;
                end
                StWaitClr: begin
                    if (!bios_wr) begin
                        r_state    <= StWrite;
                        r_rptr     <= '0;
                        r_mem_we   <= 1'b1;
                        r_mem_dout <= w_rd_data;
                    end
                end
                StWrite: begin
                    if (w_ack) begin
                        if (r_rptr == LAST) begin
                            r_mem_we <= 1'b0;
                            r_state  <= StIdle;
                        end else begin
                            r_rptr     <= w_rptr_nxt;
                            r_mem_dout <= w_rd_data;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sdr) begin
        r_din <= bios_din;
        if (r_vld[1]) r_buf[r_wptr] <= r_din;
    end

    always_ff @(posedge clk_sdr) begin
        if (!reset_n || w_clr) begin
            r_mem_addr   <= BASE_ADDR;
            r_words_done <= 16'h0000;
        end else if (w_ack) begin
            r_mem_addr <= r_mem_addr + 1'b1;
            if (r_words_done != 16'hFFFF) r_words_done <= r_words_done + 1'b1;
        end
    end

`ifdef BIOS_BURST_SINK_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk_sdr) begin
        if (!reset_n || w_clr) r_checksum <= 16'h0000;
        else if (w_ack) r_checksum <= r_checksum + r_mem_dout;
    end

    assign checksum  = r_checksum;
    assign sum_valid = (r_state == StIdle) && (r_words_done != 16'h0000);
`endif

    assign bios_req   = r_bios_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_dout   = r_mem_dout;
    assign busy       = (r_state != StIdle);
    assign words_done = r_words_done;

endmodule

// File: doc/bios_burst_sink.md
Name: bios_burst_sink

Overview:
- Consumer end of the BIOS download handshake (BIOS_WR / BIOS_REQ / BIOS_DIN).
- The producer side stages 16-bit words from the host download into a 64-word ping-pong buffer and raises bios_wr when a 32-word half is ready.
- This block pulls each half-buffer with a bios_req burst into a local line buffer, then writes it word by word into system memory through a req/ack write port.
- Sits inside system, on clk_sdr, between the download stager and the SDRAM arbiter.

Parameters:
- BURST, 32, words pulled per bios_wr event (must match the producer half-buffer size).
- ADDR_W, 18, width of the memory word address.
- BASE_ADDR, 18'h3F000, memory word address of the first BIOS word.

Ports:
- clk_sdr  in  1  SDRAM/system clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle pulse; restarts a download (pointer to BASE_ADDR, counters cleared).
- bios_wr  in  1  producer flag: a BURST-word half-buffer is ready.
- bios_din  in  16  producer data, registered by the producer one cycle after it samples bios_req.
- bios_req  out  1  held high for exactly BURST consecutive cycles per burst.
- mem_we  out  1  memory write request; held until mem_ack.
- mem_addr  out  ADDR_W  memory word address.
- mem_dout  out  16  memory write data.
- mem_ack  in  1  one-cycle acceptance of the current write.
- busy  out  1  high in any state other than IDLE.
- words_done  out  16  total words committed to memory since the last load_start.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - bios_req=0, mem_we=0, mem_addr=BASE_ADDR, mem_dout=0, busy=0, words_done=0, state=IDLE.
  - Reset aborts any burst or write in progress; the buffer contents are discarded.
- States:
  - IDLE: if bios_wr=1 go to FETCH, with the burst counter cleared.
  - FETCH: bios_req=1; count BURST cycles; after the BURST-th cycle, drop bios_req and go to DRAIN.
  - DRAIN: wait 2 cycles for the last words in flight, then go to WAIT_CLR.
  - WAIT_CLR: wait for bios_wr=0, then go to WRITE.
  - WRITE: present buffer words 0..BURST-1 in order. Each word is held on mem_we/mem_addr/mem_dout until mem_ack. After the BURST-th ack go to IDLE.
- Capture pipeline:
  - The cycle bios_req is high is cycle t; bios_din is valid and sampled at edge t+2.
  - A 2-stage valid shift register tracks requests in flight; word k is written to buffer slot k.
- Address and count updates:
  - mem_addr increments by 1 on each mem_ack and wraps modulo 2^ADDR_W.
  - words_done increments on each mem_ack and saturates at 16'hFFFF.
- Rearm rule:
  - The producer clears bios_wr one cycle after bios_req falls.
  - WAIT_CLR must see bios_wr=0 before IDLE can rearm, so a stale flag never triggers a duplicate burst.
  - A new bios_wr that rises during WRITE is serviced on return to IDLE.
- load_start:
  - Accepted only in IDLE or WAIT_CLR; it resets mem_addr and words_done and leaves the state unchanged.
  - In other states it is latched and applied on the next entry to IDLE.
- Simultaneous events:
  - bios_wr=1 and load_start in the same IDLE cycle: apply load_start first, then enter FETCH.
  - mem_ack while mem_we=0 is ignored.
- bios_req is never asserted outside FETCH. The line buffer is 16xBURST, single write port and single read port.

Optional Feature:
- Macro: BIOS_BURST_SINK_CHECKSUM_EN.
- When defined:
  - Adds output port checksum, 16 bits: modulo-2^16 sum of every word committed (updated on mem_ack).
  - Cleared by reset and by load_start.
  - Adds output port sum_valid, high in IDLE once words_done is nonzero.
- When undefined: neither port exists and no adder is instantiated.

Test Plan:
- Single burst: load_start, then bios_wr=1 with a producer model supplying words 16'h0100..16'h011F; mem_ack every cycle -> bios_req high exactly 32 cycles; 32 writes to 18'h3F000..18'h3F01F with matching data; words_done=32.
- Slow memory: mem_ack every 5th cycle -> each write held stable until ack; no dropped or duplicated words; busy stays high until the 32nd ack.
- Back-to-back halves: producer raises bios_wr again during WRITE -> second burst starts after return to IDLE; 64 sequential words land at 18'h3F000..18'h3F03F.
- Stale flag: hold bios_wr high 3 extra cycles after bios_req falls -> block waits in WAIT_CLR; exactly one burst is issued.
- Reset mid-FETCH: reset_n=0 on the 10th req cycle -> next cycle bios_req=0, mem_we=0, words_done=0, mem_addr=BASE_ADDR.
- Checksum (macro defined): words 1..32 -> checksum=16'd528 and sum_valid=1 in IDLE.
